// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the systolic array control slice:
//               feed-sequencer FSM state encoding, default array dimension,
//               data width and FIFO read latency (used to size the drain).
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_N       = 3;
    localparam int DATA_WIDTH      = 8;
    // Cycles from a FIFO read enable to data appearing at the array edge.
    localparam int FIFO_RD_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/skew_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : skew_enable_gen
// Description : Registered decode of the feed counter into an N-bit
//               diagonally skewed read-enable vector. Lane i is high while
//               i <= cnt < i+K during FEED.
// Ports       : clk      - clock
//               rstn     - asynchronous reset, active-high
//               feed_i   - next cycle is a FEED cycle
//               cnt_i    - next-cycle feed counter value
//               k_i      - next-cycle inner dimension K
//               en_o     - registered skewed enables (bit i -> FIFO i)
// Revision    : 1.0 - initial release
// ============================================================================
module skew_enable_gen #(
    parameter int N  = 3,
    parameter int KW = 8,
    parameter int CW = KW + $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          feed_i,
    input  logic [CW-1:0] cnt_i,
    input  logic [KW-1:0] k_i,
    output logic [N-1:0]  en_o
);

    logic [CW-1:0] k_ext;
    logic [N-1:0]  en_d;
    logic [N-1:0]  en_q;

    assign k_ext = {{(CW-KW){1'b0}}, k_i};

    for (genvar i = 0; i < N; i++) begin : g_lane
        // CW is wide enough that i+K never wraps for the largest K.
        assign en_d[i] = feed_i && (cnt_i >= CW'(i)) && (cnt_i < (CW'(i) + k_ext));
    end

    // Decoding the next-state counter keeps the enables registered while
    // still lining lane 0 up with the first FEED cycle.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            en_q <= '0;
        end else begin
            en_q <= en_d;
        end
    end

    assign en_o = en_q;

endmodule
`default_nettype wire

// File: rtl/systolic_feed_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feed_sequencer
// Description : Drives skewed row/column FIFO read enables for an NxN
//               systolic MAC array, waits the drain interval and pulses
//               done when all PE accumulators are final. Flags reads
//               issued to empty FIFOs (sticky until next accepted start).
// Ports       : clk, rstn (async, active-high)
//               start, k_len           - run request / inner dimension K
//               row_empty, col_empty   - FIFO empty flags
//               row_r_en, col_r_en     - skewed FIFO read enables
//               busy, done, underflow  - run status
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feed_sequencer
    import systolic_pkg::*;
#(
    parameter int N            = DEFAULT_N,
    parameter int KW           = 8,
    parameter int DRAIN_CYCLES = FIFO_RD_LATENCY + N
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic [N-1:0]  row_empty,
    input  logic [N-1:0]  col_empty,
    output logic [N-1:0]  row_r_en,
    output logic [N-1:0]  col_r_en,
    output logic          busy,
    output logic          done,
    output logic          underflow
);

    localparam int CW = KW + $clog2(N) + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;      // feed counter, reused as drain counter
    logic [KW-1:0] k_q, k_d;
    logic          underflow_q, underflow_d;
    logic [CW-1:0] k_ext;
    logic          feed_last;
    logic          drain_last;
    logic          feed_d;

    assign k_ext      = {{(CW-KW){1'b0}}, k_q};
    assign feed_last  = (cnt_q + CW'(1)) == (k_ext + CW'(N-1));
    assign drain_last = cnt_q == CW'(DRAIN_CYCLES-1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        underflow_d = underflow_q | (|(row_r_en & row_empty)) | (|(col_r_en & col_empty));
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d         = k_len;
                    cnt_d       = '0;
                    underflow_d = 1'b0;
                    state_d     = (k_len == '0) ? ST_DONE : ST_FEED;
                end
            end
            ST_FEED: begin
                if (feed_last) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            underflow_q <= underflow_d;
        end
    end

    assign feed_d = (state_d == ST_FEED);

    skew_enable_gen #(.N(N), .KW(KW), .CW(CW)) u_row_en (
        .clk    (clk),
        .rstn   (rstn),
        .feed_i (feed_d),
        .cnt_i  (cnt_d),
        .k_i    (k_d),
        .en_o   (row_r_en)
    );

    skew_enable_gen #(.N(N), .KW(KW), .CW(CW)) u_col_en (
        .clk    (clk),
        .rstn   (rstn),
        .feed_i (feed_d),
        .cnt_i  (cnt_d),
        .k_i    (k_d),
        .en_o   (col_r_en)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feed_sequencer
// Description : Self-checking bench for systolic_feed_sequencer (N=3, KW=8,
//               DRAIN_CYCLES=4). Per-edge vector table plus a hand-written
//               mid-run reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feed_sequencer;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [7:0] k_len;
    logic [2:0] row_empty;
    logic [2:0] col_empty;
    logic [2:0] row_r_en;
    logic [2:0] col_r_en;
    logic       busy;
    logic       done;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    systolic_feed_sequencer #(.N(3), .KW(8), .DRAIN_CYCLES(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .k_len     (k_len),
        .row_empty (row_empty),
        .col_empty (col_empty),
        .row_r_en  (row_r_en),
        .col_r_en  (col_r_en),
        .busy      (busy),
        .done      (done),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // One record = inputs applied before an edge, outputs expected after it.
    typedef struct packed {
        logic       start;
        logic [7:0] k;
        logic [2:0] remp;
        logic [2:0] cemp;
        logic [2:0] ren;
        logic [2:0] cen;
        logic       busy;
        logic       done;
        logic       uf;
    } vec_t;

    vec_t tbl[$];

    // Hand-computed K=4 enable pattern for the 11 cycles after acceptance.
    logic [2:0] pat [0:10] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100,
                               3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic push(input logic s, input logic [7:0] k, input logic [2:0] remp, input logic [2:0] cemp,
                        input logic [2:0] ren, input logic b, input logic d, input logic uf);
        vec_t v;
        v.start = s; v.k = k; v.remp = remp; v.cemp = cemp;
        v.ren = ren; v.cen = ren; v.busy = b; v.done = d; v.uf = uf;
        tbl.push_back(v);
    endtask

    // K=4 run: start accepted on the first record; sb[c] drives start on later
    // records, kother drives k_len after acceptance (must be ignored).
    task automatic add_run4(input logic [10:0] sb, input logic [7:0] kother, input logic [2:0] cemp, input int uf_from);
        for (int c = 0; c < 11; c++) begin
            push((c == 0) ? 1'b1 : sb[c], (c == 0) ? 8'd4 : kother, 3'b000, cemp,
                 pat[c], 1'b1, (c == 10), (uf_from >= 0) && (c >= uf_from));
        end
    endtask

    int done_seen;

    initial begin
        rstn = 1'b1; start = 1'b0; k_len = 8'd0; row_empty = 3'b000; col_empty = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_en", 0, 32'(row_r_en), 32'd0);
        chk("rst_col_en", 0, 32'(col_r_en), 32'd0);
        chk("rst_busy",   0, 32'(busy),     32'd0);
        chk("rst_done",   0, 32'(done),     32'd0);
        chk("rst_uf",     0, 32'(underflow), 32'd0);
        @(negedge clk);
        rstn = 1'b0;

        // ---- Mid-run reset at cnt=2, with empty columns so underflow is set
        start = 1'b1; k_len = 8'd4; col_empty = 3'b111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_row_en", 0, 32'(row_r_en), 32'd7);
        chk("pre_rst_uf",     0, 32'(underflow), 32'd1);
        rstn = 1'b1;
        #1;
        chk("mid_rst_row_en", 0, 32'(row_r_en), 32'd0);
        chk("mid_rst_col_en", 0, 32'(col_r_en), 32'd0);
        chk("mid_rst_busy",   0, 32'(busy),     32'd0);
        chk("mid_rst_done",   0, 32'(done),     32'd0);
        chk("mid_rst_uf",     0, 32'(underflow), 32'd0);
        col_empty = 3'b000;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("no_done_after_abort", 0, 32'(done_seen), 32'd0);
        chk("idle_after_abort",    0, 32'(busy),      32'd0);

        // ---- Vector table
        // A: plain K=4 run, then one idle cycle
        add_run4(11'd0, 8'd4, 3'b000, -1);
        push(1'b0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // B: K=0 -> done right after acceptance, no enables
        push(1'b1, 8'd0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        push(1'b0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // Empty flags with no read in flight must not raise underflow
        push(1'b0, 8'd0, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
        // C: col FIFO 2 empty; k_len wiggles to 9 after acceptance
        add_run4(11'd0, 8'd9, 3'b100, 3);
        push(1'b0, 8'd9, 3'b000, 3'b100, 3'b000, 1'b0, 1'b0, 1'b1);
        // Next accepted start (K=0) clears underflow
        push(1'b1, 8'd0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        push(1'b0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        // D: start pulsed in FEED, then held from DRAIN through DONE
        add_run4(11'b111_0000_0100, 8'd4, 3'b000, -1);
        push(1'b1, 8'd4, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        add_run4(11'd0, 8'd4, 3'b000, -1);
        push(1'b0, 8'd4, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            start     = tbl[i].start;
            k_len     = tbl[i].k;
            row_empty = tbl[i].remp;
            col_empty = tbl[i].cemp;
            @(posedge clk);
            #1;
            chk("row_r_en",  i, 32'(row_r_en),  32'(tbl[i].ren));
            chk("col_r_en",  i, 32'(col_r_en),  32'(tbl[i].cen));
            chk("busy",      i, 32'(busy),      32'(tbl[i].busy));
            chk("done",      i, 32'(done),      32'(tbl[i].done));
            chk("underflow", i, 32'(underflow), 32'(tbl[i].uf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
